// File: rtl/stream_loopback_fifo.sv
// Host stream loopback: buffers incoming words, XORs them with a programmable key
// and streams them back, with register-port control/status and LED indicators.
module stream_loopback_fifo #(
  parameter int AW          = 9,
  parameter int BUSY_MARGIN = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] in_data,
  input  logic        in_we,
  output logic        in_busy,
  output logic [15:0] out_data,
  output logic        out_we,
  input  logic        out_busy,
  input  logic [9:0]  reg_addr,
  input  logic [7:0]  reg_data_in,
  input  logic        reg_we,
  input  logic        reg_re,
  output logic [7:0]  reg_data_out,
  output logic [7:0]  leds
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0] BUSY_LEVEL = (AW+1)'(DEPTH - BUSY_MARGIN);

  localparam logic [9:0] A_CTRL     = 10'h000;
  localparam logic [9:0] A_KEY_LO   = 10'h001;
  localparam logic [9:0] A_KEY_HI   = 10'h002;
  localparam logic [9:0] A_STATUS   = 10'h003;
  localparam logic [9:0] A_LEVEL_LO = 10'h004;
  localparam logic [9:0] A_LEVEL_HI = 10'h005;
  localparam logic [9:0] A_COUNT0   = 10'h006;
  localparam logic [9:0] A_COUNT1   = 10'h007;
  localparam logic [9:0] A_COUNT2   = 10'h008;
  localparam logic [9:0] A_COUNT3   = 10'h009;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic          enable;
  logic [15:0]   key;
  logic          overflow;
  logic [31:0]   count;
  logic [31:0]   snapshot;

  logic ctrl_wr;
  logic flush;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic overflow_set;

  assign ctrl_wr = reg_we && (reg_addr == A_CTRL);
  assign flush   = ctrl_wr && reg_data_in[1];
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign pop     = enable && !empty && !out_busy && !flush;
  // At full a write is still accepted when a pop frees the slot in the same cycle.
  assign push         = in_we && (!full || pop) && !flush;
  assign overflow_set = in_we && full && !pop && !flush;

  always_comb begin
    level_next = level;
    if (flush)
      level_next = '0;
    else if (push && !pop)
      level_next = level + 1'b1;
    else if (pop && !push)
      level_next = level - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      in_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      level   <= level_next;
      in_busy <= (level_next >= BUSY_LEVEL);
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (overflow_set)
          overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_we   <= 1'b0;
      out_data <= '0;
      count    <= '0;
      snapshot <= '0;
    end else begin
      out_we <= pop;
      if (pop)
        out_data <= mem[rd_ptr] ^ key;
      if (flush)
        count <= '0;
      else if (out_we)
        count <= count + 32'd1;
      if (reg_re && (reg_addr == A_COUNT0))
        snapshot <= count;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enable <= 1'b0;
      key    <= '0;
    end else if (reg_we) begin
      case (reg_addr)
        A_CTRL:   enable    <= reg_data_in[0];
        A_KEY_LO: key[7:0]  <= reg_data_in;
        A_KEY_HI: key[15:8] <= reg_data_in;
        default:  ;
      endcase
    end
  end

  // Byte 0 follows the live counter on the loading read so all four bytes agree.
  always_comb begin
    reg_data_out = 8'h00;
    case (reg_addr)
      A_CTRL:     reg_data_out = {7'b0, enable};
      A_KEY_LO:   reg_data_out = key[7:0];
      A_KEY_HI:   reg_data_out = key[15:8];
      A_STATUS:   reg_data_out = {4'b0, in_busy, overflow, full, empty};
      A_LEVEL_LO: reg_data_out = 8'(level);
      A_LEVEL_HI: reg_data_out = 8'(level >> 8);
      A_COUNT0:   reg_data_out = reg_re ? count[7:0] : snapshot[7:0];
      A_COUNT1:   reg_data_out = snapshot[15:8];
      A_COUNT2:   reg_data_out = snapshot[23:16];
      A_COUNT3:   reg_data_out = snapshot[31:24];
      default:    reg_data_out = 8'h00;
    endcase
  end

  assign leds = {level[AW -: 4], count[12], !empty, overflow, enable};

endmodule

// File: tb/tb_stream_loopback_fifo.sv
// Bench for stream_loopback_fifo: random stream data checked every cycle against a
// queue-based reference model, plus directed register and boundary steps.
module tb_stream_loopback_fifo;

  localparam int DEPTH = 512;
  localparam int BUSY  = 508;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_we = 1'b0;
  logic        in_busy;
  logic [15:0] out_data;
  logic        out_we;
  logic        out_busy = 1'b0;
  logic [9:0]  reg_addr = '0;
  logic [7:0]  reg_data_in = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [7:0]  reg_data_out;
  logic [7:0]  leds;

  always #5 CLK = ~CLK;

  stream_loopback_fifo #(.AW(9), .BUSY_MARGIN(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_we(in_we), .in_busy(in_busy),
    .out_data(out_data), .out_we(out_we), .out_busy(out_busy),
    .reg_addr(reg_addr), .reg_data_in(reg_data_in), .reg_we(reg_we), .reg_re(reg_re),
    .reg_data_out(reg_data_out), .leds(leds)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] q[$];
  logic [15:0] seen[$];
  bit          m_en;
  logic [15:0] m_key;
  bit          m_ovf;
  logic [31:0] m_cnt;
  logic [31:0] m_snap;
  bit          m_pend;
  logic [15:0] m_pend_data;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_reg(logic [9:0] a, logic re);
    logic [9:0] lvl;
    logic [7:0] r;
    lvl = 10'(q.size());
    r = 8'h00;
    case (a)
      10'h000: r = {7'b0, m_en};
      10'h001: r = m_key[7:0];
      10'h002: r = m_key[15:8];
      10'h003: r = {4'b0, q.size() >= BUSY, m_ovf, q.size() == DEPTH, q.size() == 0};
      10'h004: r = lvl[7:0];
      10'h005: r = {6'b0, lvl[9:8]};
      10'h006: r = re ? m_cnt[7:0] : m_snap[7:0];
      10'h007: r = m_snap[15:8];
      10'h008: r = m_snap[23:16];
      10'h009: r = m_snap[31:24];
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] model_leds();
    logic [9:0] lvl;
    lvl = 10'(q.size());
    return {lvl[9:6], m_cnt[12], q.size() != 0, m_ovf, m_en};
  endfunction

  // Model advances on each rising edge from the inputs the DUT saw, then compares.
  always @(posedge CLK) begin : model
    bit flush_c, pop_c, full_c;
    if (RST) begin
      q.delete();
      m_en = 0; m_key = '0; m_ovf = 0; m_cnt = '0; m_snap = '0; m_pend = 0; m_pend_data = '0;
    end else begin
      if (reg_re && reg_addr == 10'h006) m_snap = m_cnt;
      flush_c = reg_we && reg_addr == 10'h000 && reg_data_in[1];
      full_c  = (q.size() == DEPTH);
      pop_c   = m_en && q.size() != 0 && !out_busy && !flush_c;
      if (flush_c) begin
        q.delete(); m_ovf = 0; m_cnt = '0; m_pend = 0;
      end else begin
        if (m_pend) m_cnt++;
        m_pend = pop_c;
        if (pop_c) m_pend_data = q.pop_front() ^ m_key;
        if (in_we) begin
          if (!full_c || pop_c) q.push_back(in_data);
          else m_ovf = 1;
        end
      end
      if (reg_we) begin
        case (reg_addr)
          10'h000: m_en = reg_data_in[0];
          10'h001: m_key[7:0] = reg_data_in;
          10'h002: m_key[15:8] = reg_data_in;
          default: ;
        endcase
      end
    end
    #1;
    check("out_we", out_we, m_pend);
    if (m_pend) check("out_data", out_data, m_pend_data);
    if (out_we) seen.push_back(out_data);
    check("in_busy", in_busy, q.size() >= BUSY);
    check("reg_data_out", reg_data_out, model_reg(reg_addr, reg_re));
    check("leds", leds, model_leds());
  end

  task automatic reg_write(logic [9:0] a, logic [7:0] d);
    @(negedge CLK);
    reg_addr = a; reg_data_in = d; reg_we = 1'b1;
    @(negedge CLK);
    reg_we = 1'b0;
  endtask

  task automatic push_word(logic [15:0] d);
    @(negedge CLK);
    in_we = 1'b1; in_data = d;
    @(negedge CLK);
    in_we = 1'b0;
  endtask

  // Leaves in_we high on exit; caller decides the next input.
  task automatic stream(int n, bit toggle_busy);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      in_we = 1'b1; in_data = 16'($urandom);
      out_busy = toggle_busy ? ~out_busy : 1'b0;
    end
  endtask

  task automatic wait_empty(int budget);
    int n = 0;
    while ((leds[2] || out_we) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", n < budget, 1);
  endtask

  task automatic read_count(logic [31:0] exp);
    @(negedge CLK);
    reg_addr = 10'h006; reg_re = 1'b1;
    @(negedge CLK);
    reg_re = 1'b0;
    for (int b = 0; b < 4; b++) begin
      reg_addr = 10'(6 + b);
      #1;
      check($sformatf("count_b%0d", b), reg_data_out, exp[8*b +: 8]);
      @(negedge CLK);
    end
  endtask

  task automatic read_reg(logic [9:0] a, logic [7:0] exp, string tag);
    reg_addr = a;
    #1;
    check(tag, reg_data_out, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    #2 RST = 1'b1;
    #1;
    check("rst_out_we", out_we, 0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in_busy", in_busy, 0);
    check("rst_leds", leds, 8'h00);
    check("rst_ctrl", reg_data_out, 8'h00);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    read_reg(10'h003, 8'h01, "rst_status");

    // basic loopback with zero key
    reg_write(10'h000, 8'h01);
    reg_write(10'h001, 8'h00);
    reg_write(10'h002, 8'h00);
    seen.delete();
    push_word(16'h1234);
    push_word(16'hABCD);
    wait_empty(50);
    check("basic_n", seen.size(), 2);
    if (seen.size() == 2) begin
      check("basic_w0", seen[0], 16'h1234);
      check("basic_w1", seen[1], 16'hABCD);
    end
    read_count(32'd2);
    read_reg(10'h003, 8'h01, "basic_status");

    // key applied
    reg_write(10'h002, 8'hFF);
    reg_write(10'h001, 8'h00);
    seen.delete();
    push_word(16'h00AA);
    wait_empty(50);
    check("key_n", seen.size(), 1);
    if (seen.size() == 1) check("key_w0", seen[0], 16'hFFAA);

    // fill to busy threshold, full, then overflow
    reg_write(10'h000, 8'h00);
    stream(508, 0);
    @(negedge CLK);
    in_we = 1'b0;
    #1 check("busy_at_508", in_busy, 1);
    read_reg(10'h004, 8'hFC, "level_lo_508");
    read_reg(10'h005, 8'h01, "level_hi_508");
    stream(4, 0);
    @(negedge CLK);
    in_we = 1'b0;
    read_reg(10'h003, 8'h0A, "status_full");
    stream(1, 0);
    @(negedge CLK);
    in_we = 1'b0;
    read_reg(10'h003, 8'h0E, "status_ovf");
    check("led_ovf", leds[1], 1);

    // drain from full with out_busy toggling and input held on
    reg_write(10'h000, 8'h01);
    stream(400, 1);
    @(negedge CLK);
    in_we = 1'b0; out_busy = 1'b0;
    wait_empty(2000);

    // flush mid-stream
    stream(300, 0);
    @(negedge CLK);
    in_we = 1'b1; in_data = 16'($urandom);
    reg_addr = 10'h000; reg_data_in = 8'h03; reg_we = 1'b1;
    @(negedge CLK);
    in_we = 1'b0; reg_we = 1'b0;
    #1 check("flush_out_we", out_we, 0);
    read_reg(10'h004, 8'h00, "flush_level");
    read_reg(10'h003, 8'h01, "flush_status");
    read_count(32'd0);
    stream(300, 0);
    @(negedge CLK);
    in_we = 1'b0;
    wait_empty(100);
    read_count(32'd300);

    // reset during streaming
    stream(20, 0);
    @(negedge CLK);
    RST = 1'b1; in_we = 1'b0;
    reg_addr = 10'h000;
    #1;
    check("midrst_out_we", out_we, 0);
    check("midrst_out_data", out_data, 16'h0000);
    check("midrst_in_busy", in_busy, 0);
    check("midrst_leds", leds, 8'h00);
    check("midrst_ctrl", reg_data_out, 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    seen.delete();
    push_word(16'h5A5A);
    repeat (10) @(negedge CLK);
    check("postrst_held", seen.size(), 0);
    reg_write(10'h000, 8'h01);
    wait_empty(50);
    check("postrst_n", seen.size(), 1);
    if (seen.size() == 1) check("postrst_w0", seen[0], 16'h5A5A);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
